// File: rtl/rs232_avalon_slave.sv
// Avalon-MM slave UART (8N1) with RX / TX / STATUS registers at byte addresses 0 / 4 / 8.
// Every bus access takes two cycles: a stall cycle that captures read data, then an accept cycle.
module rs232_avalon_slave #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  output logic [31:0] avm_readdata,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  localparam logic [1:0] T_IDLE = 2'd0, T_START = 2'd1, T_DATA = 2'd2, T_STOP = 2'd3;

  logic          ack_r;
  logic          req, read_accept, write_accept, rx_clear, tx_load;
  logic [31:0]   read_mux, status;
  logic          unused_wdata;

  logic          rxd_meta, rxd_sync;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_full, overrun, frame_err;
  logic          stop_sample, stop_ok, stop_bad;

  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_busy;

  assign req             = avm_read | avm_write;
  assign avm_waitrequest = req & ~ack_r;
  assign read_accept     = avm_read & ack_r;
  assign write_accept    = avm_write & ~avm_read & ack_r;
  assign rx_clear        = read_accept & (avm_address == 5'd0) & rx_full;
  assign tx_load         = write_accept & (avm_address == 5'd4) & ~tx_busy;
  assign tx_busy         = (tx_state != T_IDLE);
  assign unused_wdata    = ^avm_writedata[31:8];

  assign status = {24'b0, rx_full, ~tx_busy, 2'b00, overrun, frame_err, 2'b00};

  always_comb begin
    read_mux = '0;
    case (avm_address)
      5'd0:    read_mux = {24'b0, rx_byte};
      5'd8:    read_mux = status;
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      ack_r        <= 1'b0;
      avm_readdata <= '0;
    end else begin
      ack_r <= req & ~ack_r;
      if (avm_read && !ack_r) avm_readdata <= read_mux;
    end
  end

  // Receiver: start bit is re-checked at its midpoint, so later samples land mid-bit.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      case (rx_state)
        R_IDLE: begin
          if (!rxd_sync) begin
            rx_state <= R_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        R_START: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - CNT_ONE;
          else if (rxd_sync) rx_state <= R_IDLE;
          else begin
            rx_state <= R_DATA;
            rx_cnt   <= BIT_LAST;
            rx_bit   <= '0;
          end
        end
        R_DATA: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - CNT_ONE;
          else begin
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_bit == 3'd7) rx_state <= R_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - CNT_ONE;
          else rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  assign stop_sample = (rx_state == R_STOP) && (rx_cnt == '0);
  assign stop_ok     = stop_sample & rxd_sync;
  assign stop_bad    = stop_sample & ~rxd_sync;

  // A new stop sample beats a same-cycle RX read clear.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rx_full   <= 1'b0;
      rx_byte   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (stop_ok) rx_full <= 1'b1;
      else if (rx_clear) rx_full <= 1'b0;

      if (stop_ok && (!rx_full || rx_clear)) rx_byte <= rx_shift;

      if (stop_ok && rx_full && !rx_clear) overrun <= 1'b1;
      else if (rx_clear) overrun <= 1'b0;

      if (stop_bad) frame_err <= 1'b1;
      else if (rx_clear) frame_err <= 1'b0;
    end
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (tx_load) begin
            tx_state <= T_START;
            tx_cnt   <= BIT_LAST;
            tx_shift <= avm_writedata[7:0];
            uart_txd <= 1'b0;
          end
        end
        T_START: begin
          if (tx_cnt != '0) tx_cnt <= tx_cnt - CNT_ONE;
          else begin
            tx_state <= T_DATA;
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            uart_txd <= tx_shift[0];
          end
        end
        T_DATA: begin
          if (tx_cnt != '0) tx_cnt <= tx_cnt - CNT_ONE;
          else begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              tx_state <= T_STOP;
              uart_txd <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              uart_txd <= tx_shift[1];
            end
          end
        end
        T_STOP: begin
          if (tx_cnt != '0) tx_cnt <= tx_cnt - CNT_ONE;
          else tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_avalon_slave.sv
// Self-checking bench for rs232_avalon_slave with CLKS_PER_BIT = 4, compared against a
// cycle-count model of the register map, the RX flag rules and the TX frame timing.
module tb_rs232_avalon_slave;

  localparam int CPB  = 4;
  localparam int HIST = 16384;

  logic        avm_clk = 1'b0;
  logic        avm_rst_n = 1'b0;
  logic [4:0]  avm_address = '0;
  logic        avm_read = 1'b0;
  logic [31:0] avm_readdata;
  logic        avm_write = 1'b0;
  logic [31:0] avm_writedata = '0;
  logic        avm_waitrequest;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic txd_hist [HIST];

  // Reference model state
  logic       rx_full_m, ovr_m, fe_m;
  logic [7:0] rx_byte_m, tx_byte_m;
  int         tx_idle_at, tx_start;

  rs232_avalon_slave #(.CLKS_PER_BIT(CPB)) dut (
    .avm_clk(avm_clk), .avm_rst_n(avm_rst_n), .avm_address(avm_address),
    .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  always #5 avm_clk = ~avm_clk;
  always @(posedge avm_clk) cyc <= cyc + 1;
  always @(negedge avm_clk) if (cyc < HIST) txd_hist[cyc] <= uart_txd;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] exp_status(input int at);
    return {24'b0, rx_full_m, (at >= tx_idle_at), 2'b00, ovr_m, fe_m, 2'b00};
  endfunction

  task automatic model_reset();
    rx_full_m = 1'b0; ovr_m = 1'b0; fe_m = 1'b0; rx_byte_m = '0;
    tx_idle_at = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge avm_clk);
    #1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output int waits, output int at);
    at = cyc;
    avm_address = a;
    avm_read = 1'b1;
    waits = 0;
    #1;
    while (avm_waitrequest === 1'b1 && waits < 8) begin
      waits++;
      @(negedge avm_clk); #1;
    end
    d = avm_readdata;
    @(negedge avm_clk);
    avm_read = 1'b0;
    #1;
    if (a == 5'd0 && rx_full_m) begin
      rx_full_m = 1'b0; ovr_m = 1'b0; fe_m = 1'b0;
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d, output int waits);
    int c1;
    avm_address = a;
    avm_writedata = {24'($urandom), d};
    avm_write = 1'b1;
    waits = 0;
    #1;
    while (avm_waitrequest === 1'b1 && waits < 8) begin
      waits++;
      @(negedge avm_clk); #1;
    end
    c1 = cyc;
    @(negedge avm_clk);
    avm_write = 1'b0;
    #1;
    if (a == 5'd4 && c1 >= tx_idle_at) begin
      tx_start   = c1 + 1;
      tx_idle_at = c1 + 1 + 10 * CPB;
      tx_byte_m  = d;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    for (int k = 0; k < 10; k++) begin
      uart_rxd = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : d[k-1];
      repeat (CPB) @(negedge avm_clk);
      #1;
    end
    uart_rxd = 1'b1;
    if (!stop_bit) fe_m = 1'b1;
    else if (rx_full_m) ovr_m = 1'b1;
    else begin
      rx_full_m = 1'b1;
      rx_byte_m = d;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; int w, at;
    avm_rst_n = 1'b0;
    model_reset();
    wait_cycles(3);
    tests++; if (avm_readdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_readdata: got %h expected 0", avm_readdata); end
    tests++; if (uart_txd !== 1'b1) begin fails++; $display("[TB] FAIL reset_txd: got %b expected 1", uart_txd); end
    tests++; if (avm_waitrequest !== 1'b0) begin fails++; $display("[TB] FAIL reset_wait: got %b expected 0", avm_waitrequest); end
    avm_rst_n = 1'b1;
    wait_cycles(2);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL reset_status: got %h expected %h", d, exp_status(at)); end
    tests++; if (w !== 1) begin fails++; $display("[TB] FAIL reset_wait_cycles: got %0d expected 1", w); end
  endtask

  task automatic test_tx();
    logic [31:0] d; int w, at, s; logic expb;
    bus_write(5'd4, 8'hA5, w);
    tests++; if (w !== 1) begin fails++; $display("[TB] FAIL tx_write_wait: got %0d expected 1", w); end
    s = tx_start;
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL tx_status_busy: got %h expected %h", d, exp_status(at)); end
    wait_cycles(6);
    bus_write(5'd4, 8'($urandom), w);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL tx_status_busy2: got %h expected %h", d, exp_status(at)); end
    if (cyc < s + 10 * CPB + 2) wait_cycles(s + 10 * CPB + 2 - cyc);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL tx_status_done: got %h expected %h", d, exp_status(at)); end
    if (cyc < s + 60) wait_cycles(s + 60 - cyc);
    for (int j = 0; j < 56; j++) begin
      expb = (j < CPB) ? 1'b0 : (j < 9 * CPB) ? tx_byte_m[(j - CPB) / CPB] : 1'b1;
      tests++;
      if (txd_hist[s + j] !== expb) begin
        fails++; $display("[TB] FAIL tx_bit[%0d]: got %b expected %b", j, txd_hist[s + j], expb);
      end
    end
  endtask

  task automatic test_rx();
    logic [31:0] d, e; int w, at;
    send_frame(8'h3C, 1'b1);
    wait_cycles(2);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL rx_status_full: got %h expected %h", d, exp_status(at)); end
    bus_write(5'd4, 8'($urandom), w);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL rx_status_txbusy: got %h expected %h", d, exp_status(at)); end
    if (cyc < tx_idle_at + 1) wait_cycles(tx_idle_at + 1 - cyc);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL rx_status_txidle: got %h expected %h", d, exp_status(at)); end
    e = {24'b0, rx_byte_m};
    bus_read(5'd0, d, w, at);
    tests++; if (d !== e) begin fails++; $display("[TB] FAIL rx_data: got %h expected %h", d, e); end
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL rx_status_after: got %h expected %h", d, exp_status(at)); end
  endtask

  task automatic test_overrun();
    logic [31:0] d, e; int w, at;
    send_frame(8'h11, 1'b1);
    wait_cycles(2);
    send_frame(8'h22, 1'b1);
    wait_cycles(2);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL ovr_status: got %h expected %h", d, exp_status(at)); end
    e = {24'b0, rx_byte_m};
    bus_read(5'd0, d, w, at);
    tests++; if (d !== e) begin fails++; $display("[TB] FAIL ovr_data: got %h expected %h", d, e); end
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL ovr_status_after: got %h expected %h", d, exp_status(at)); end
  endtask

  task automatic test_framing_glitch();
    logic [31:0] d, e; int w, at;
    send_frame(8'($urandom), 1'b0);
    wait_cycles(4);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL frame_status: got %h expected %h", d, exp_status(at)); end
    uart_rxd = 1'b0;
    wait_cycles(1);
    uart_rxd = 1'b1;
    wait_cycles(20);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL glitch_status: got %h expected %h", d, exp_status(at)); end
    e = {24'b0, rx_byte_m};
    bus_read(5'd0, d, w, at);
    tests++; if (d !== e) begin fails++; $display("[TB] FAIL empty_read_data: got %h expected %h", d, e); end
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL empty_read_status: got %h expected %h", d, exp_status(at)); end
    send_frame(8'($urandom), 1'b1);
    wait_cycles(2);
    e = {24'b0, rx_byte_m};
    bus_read(5'd0, d, w, at);
    tests++; if (d !== e) begin fails++; $display("[TB] FAIL recover_data: got %h expected %h", d, e); end
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL recover_status: got %h expected %h", d, exp_status(at)); end
  endtask

  task automatic test_edge_cases();
    logic [31:0] d; int w, at; logic [4:0] a;
    bus_read(5'd12, d, w, at);
    tests++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL addr12_read: got %h expected 0", d); end
    bus_write(5'd12, 8'($urandom), w);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL addr12_write_status: got %h expected %h", d, exp_status(at)); end
    tests++; if (uart_txd !== 1'b1) begin fails++; $display("[TB] FAIL addr12_write_txd: got %b expected 1", uart_txd); end
    for (int i = 0; i < 4; i++) begin
      a = 5'($urandom_range(31));
      if (a == 5'd0 || a == 5'd4 || a == 5'd8) a = 5'd20;
      bus_read(a, d, w, at);
      tests++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL undecoded_read[%0d]: got %h expected 0", a, d); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e; int w, at, s; logic expb; logic [7:0] tb, rb;
    for (int it = 0; it < 6; it++) begin
      tb = 8'($urandom);
      rb = 8'($urandom);
      bus_write(5'd4, tb, w);
      s = tx_start;
      send_frame(rb, 1'b1);
      wait_cycles(2);
      bus_read(5'd8, d, w, at);
      tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL rand_status[%0d]: got %h expected %h", it, d, exp_status(at)); end
      e = {24'b0, rx_byte_m};
      bus_read(5'd0, d, w, at);
      tests++; if (d !== e) begin fails++; $display("[TB] FAIL rand_rx[%0d]: got %h expected %h", it, d, e); end
      if (cyc < s + 60) wait_cycles(s + 60 - cyc);
      for (int j = 0; j < 48; j++) begin
        expb = (j < CPB) ? 1'b0 : (j < 9 * CPB) ? tx_byte_m[(j - CPB) / CPB] : 1'b1;
        tests++;
        if (txd_hist[s + j] !== expb) begin
          fails++; $display("[TB] FAIL rand_tx[%0d] bit %0d: got %b expected %b", it, j, txd_hist[s + j], expb);
        end
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d, e; int w, at, s;
    bus_write(5'd4, 8'h00, w);
    s = cyc;
    wait_cycles(2 * CPB + 1);
    tests++; if (uart_txd !== 1'b0) begin fails++; $display("[TB] FAIL midtx_txd_before: got %b expected 0", uart_txd); end
    avm_rst_n = 1'b0;
    #1;
    tests++; if (uart_txd !== 1'b1) begin fails++; $display("[TB] FAIL midtx_txd_reset: got %b expected 1", uart_txd); end
    model_reset();
    wait_cycles(3);
    avm_rst_n = 1'b1;
    s = cyc;
    wait_cycles(2);
    bus_read(5'd8, d, w, at);
    tests++; if (d !== exp_status(at)) begin fails++; $display("[TB] FAIL midtx_status: got %h expected %h", d, exp_status(at)); end
    e = {24'b0, rx_byte_m};
    bus_read(5'd0, d, w, at);
    tests++; if (d !== e) begin fails++; $display("[TB] FAIL midtx_rxbyte: got %h expected %h", d, e); end
    wait_cycles(40);
    for (int j = 0; j < 44; j++) begin
      tests++;
      if (txd_hist[s + j] !== 1'b1) begin
        fails++; $display("[TB] FAIL midtx_idle_line[%0d]: got %b expected 1", j, txd_hist[s + j]);
      end
    end
  endtask

  initial begin
    tx_byte_m = '0;
    tx_start = 0;
    model_reset();
    test_reset();
    test_tx();
    test_rx();
    test_overrun();
    test_framing_glitch();
    test_edge_cases();
    test_random();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
